// File: rtl/apb_cfg_master.sv
// apb_cfg_master
//   Runs a fixed six-transfer APB configuration sequence: writes the start
//   address, end address and control word to 0x0/0x4/0x8, then reads them
//   back and compares against the values captured when the sequence began.
//
// Ports
//   pclock, presetn        clock (rising edge) / asynchronous active-low reset
//   cfg_start              one-cycle request to run the sequence (ignored while busy)
//   cfg_start_addr         value written to 0x0
//   cfg_end_addr           value written to 0x4
//   cfg_ctrl[1:0]          bit0 enable, bit1 xor; written to 0x8 bits [1:0]
//   cfg_busy               high while a sequence runs
//   cfg_done               one-cycle pulse when a sequence ends
//   cfg_err[1:0]           00 ok, 01 pslverr, 10 readback mismatch, 11 timeout
//   psel, penable, pwrite  APB control
//   paddr, pwdata          APB address / write data
//   prdata, pready, pslverr APB slave response
module apb_cfg_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclock,
  input  logic                  presetn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
  input  logic [1:0]            cfg_ctrl,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [1:0]            cfg_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [ADDR_WIDTH-1:0] pwdata,
  input  logic [ADDR_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_SLV      = 2'b01,
    ERR_MISMATCH = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_t;

  state_t                state_q, state_d;
  logic [2:0]            step_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [ADDR_WIDTH-1:0] start_q, end_q;
  logic [1:0]            ctrl_q;
  err_t                  err_q;

  logic start_ok;
  logic xfer_done;
  logic timed_out;
  logic last_step;
  logic is_read;
  logic readback_ok;

  assign start_ok  = (state_q == IDLE) && cfg_start;
  assign xfer_done = (state_q == ACCESS) && pready;
  assign timed_out = (state_q == ACCESS) && !pready &&
                     (wait_q == WAIT_W'(TIMEOUT - 1));
  assign last_step = (step_q == 3'd5);
  assign is_read   = (step_q >= 3'd3);
  assign cfg_err   = err_q;

  // Control readback only carries two meaningful bits.
  always_comb begin
    readback_ok = 1'b1;
    case (step_q)
      3'd3:    readback_ok = (prdata == start_q);
      3'd4:    readback_ok = (prdata == end_q);
      3'd5:    readback_ok = (prdata[1:0] == ctrl_q);
      default: readback_ok = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (cfg_start) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (pslverr || last_step) state_d = DONE;
          else                      state_d = SETUP;
        end else if (timed_out) begin
          state_d = DONE;
        end
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure decode of state and step, so reset clears them at once
  always_comb begin
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    cfg_busy = (state_q != IDLE);
    cfg_done = (state_q == DONE);
    if ((state_q == SETUP) || (state_q == ACCESS)) begin
      psel    = 1'b1;
      penable = (state_q == ACCESS);
      pwrite  = !is_read;
      case (step_q)
        3'd0: begin paddr = ADDR_WIDTH'(0); pwdata = start_q; end
        3'd1: begin paddr = ADDR_WIDTH'(4); pwdata = end_q;   end
        3'd2: begin paddr = ADDR_WIDTH'(8); pwdata = {{(ADDR_WIDTH-2){1'b0}}, ctrl_q}; end
        3'd3: paddr = ADDR_WIDTH'(0);
        3'd4: paddr = ADDR_WIDTH'(4);
        3'd5: paddr = ADDR_WIDTH'(8);
        default: paddr = '0;
      endcase
    end
  end

  // Sequence datapath: shadows, step/wait counters, error capture.
  // Only the first error of a run is recorded; within one edge pslverr
  // outranks a mismatch, and a timeout cannot coincide with either.
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      step_q  <= '0;
      wait_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
      ctrl_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      if (start_ok) begin
        start_q <= cfg_start_addr;
        end_q   <= cfg_end_addr;
        ctrl_q  <= cfg_ctrl;
        err_q   <= ERR_OK;
        step_q  <= '0;
        wait_q  <= '0;
      end
      case (state_q)
        SETUP:  wait_q <= '0;
        ACCESS: begin
          if (xfer_done) begin
            step_q <= step_q + 3'd1;
            if (err_q == ERR_OK) begin
              if (pslverr)                       err_q <= ERR_SLV;
              else if (is_read && !readback_ok)  err_q <= ERR_MISMATCH;
            end
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
            if (timed_out && (err_q == ERR_OK)) err_q <= ERR_TIMEOUT;
          end
        end
        DONE:   begin
          step_q <= '0;
          wait_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Directed bench for apb_cfg_master with a small APB responder that stores
// writes and echoes them on reads, with knobs for wait states, stalls,
// slave errors and read-data overrides.
module tb_apb_cfg_master;

  localparam int AW = 32;

  logic          pclock = 1'b0;
  logic          presetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [AW-1:0] cfg_end_addr = '0;
  logic [1:0]    cfg_ctrl = '0;
  logic          cfg_busy, cfg_done;
  logic [1:0]    cfg_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr, pwdata, prdata;
  logic          pready, pslverr;

  always #5 pclock = ~pclock;

  apb_cfg_master #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .pclock(pclock), .presetn(presetn),
    .cfg_start(cfg_start), .cfg_start_addr(cfg_start_addr),
    .cfg_end_addr(cfg_end_addr), .cfg_ctrl(cfg_ctrl),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Responder state and knobs
  logic [31:0] mem [4];
  int          wait_states = 0;
  int          wcnt = 0;
  bit          stall = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_addr = '0;
  logic [31:0] ovr_val = '0;

  assign pready  = !stall && (wcnt >= wait_states);
  assign pslverr = err_en && psel && penable && pwrite && (paddr == err_addr);

  always_comb begin
    prdata = mem[paddr[3:2]];
    if (ovr_en && !pwrite && (paddr == ovr_addr)) prdata = ovr_val;
  end

  // Transfer log
  logic [31:0] log_addr  [16];
  logic [31:0] log_wdata [16];
  bit          log_wr    [16];
  int          n_xfer = 0, acc_cycles = 0, unstable = 0, n_done = 0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic        s_wr = 1'b0;

  always @(posedge pclock) begin
    if (cfg_done) n_done++;
    if (psel && !penable) begin
      s_addr  = paddr;
      s_wdata = pwdata;
      s_wr    = pwrite;
      wcnt   <= 0;
    end else if (psel && penable) begin
      acc_cycles++;
      if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_wr) unstable++;
      if (pready) begin
        if (n_xfer < 16) begin
          log_addr[n_xfer]  = paddr;
          log_wdata[n_xfer] = pwdata;
          log_wr[n_xfer]    = pwrite;
        end
        n_xfer++;
        if (pwrite) mem[paddr[3:2]] <= pwdata;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    n_xfer = 0; acc_cycles = 0; unstable = 0; n_done = 0;
  endtask

  // Pulses cfg_start, optionally re-pulses it mid-run with a different
  // start address, and returns the cycle (start cycle = 0) where cfg_done
  // is first seen.
  task automatic run_seq(input logic [31:0] sa, input logic [31:0] ea,
                         input logic [1:0] ctl, input int restart_at,
                         output int lat);
    @(negedge pclock);
    cfg_start_addr = sa;
    cfg_end_addr   = ea;
    cfg_ctrl       = ctl;
    cfg_start      = 1'b1;
    clear_log();
    @(negedge pclock);
    cfg_start = 1'b0;
    lat = 1;
    chk("busy_on_accept", cfg_busy, 1'b1);
    chk("err_clear_on_accept", cfg_err, 2'b00);
    while (!cfg_done && lat < 400) begin
      if (lat == restart_at) begin
        cfg_start      = 1'b1;
        cfg_start_addr = 32'hDEAD_0000;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge pclock);
      lat++;
    end
    cfg_start = 1'b0;
    chk("done_seen", cfg_done, 1'b1);
    @(negedge pclock);
    chk("done_one_cycle", cfg_done, 1'b0);
    chk("busy_off_after_done", cfg_busy, 1'b0);
  endtask

  logic [31:0] exp_addr [6];
  logic [31:0] exp_wd   [6];
  bit          exp_wr   [6];
  int          lat;
  int          guard;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    exp_wd   = '{32'h1000, 32'h1FFF, 32'h1, 32'h0, 32'h0, 32'h0};
    exp_wr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge pclock);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 2'b00);
    presetn = 1'b1;
    repeat (2) @(negedge pclock);
    chk("idle_after_rst", cfg_busy, 1'b0);

    // Nominal
    run_seq(32'h1000, 32'h1FFF, 2'b01, -1, lat);
    chk("nom_latency", lat, 13);
    chk("nom_nxfer", n_xfer, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("nom_addr%0d", i), log_addr[i], exp_addr[i]);
      chk($sformatf("nom_wr%0d", i), log_wr[i], exp_wr[i]);
      chk($sformatf("nom_wdata%0d", i), log_wdata[i], exp_wd[i]);
    end
    chk("nom_err", cfg_err, 2'b00);
    chk("nom_ndone", n_done, 1);

    // Three wait states on every transfer
    wait_states = 3;
    run_seq(32'h1000, 32'h1FFF, 2'b01, -1, lat);
    wait_states = 0;
    chk("ws_latency", lat, 31);
    chk("ws_acc_cycles", acc_cycles, 24);
    chk("ws_nxfer", n_xfer, 6);
    chk("ws_stable", unstable, 0);
    chk("ws_err", cfg_err, 2'b00);

    // Slave error on the write to 0x4
    err_en = 1'b1; err_addr = 32'h4;
    run_seq(32'h2000, 32'h2FFF, 2'b11, -1, lat);
    err_en = 1'b0;
    chk("slv_nxfer", n_xfer, 2);
    chk("slv_last_addr", log_addr[1], 32'h4);
    chk("slv_latency", lat, 5);
    chk("slv_ndone", n_done, 1);
    chk("slv_err", cfg_err, 2'b01);

    // Readback mismatch on 0x0, sequence continues
    ovr_en = 1'b1; ovr_addr = 32'h0; ovr_val = 32'h1001;
    run_seq(32'h1000, 32'h1FFF, 2'b01, -1, lat);
    ovr_en = 1'b0;
    chk("mm_nxfer", n_xfer, 6);
    chk("mm_latency", lat, 13);
    chk("mm_err", cfg_err, 2'b10);
    repeat (3) @(negedge pclock);
    chk("mm_err_held", cfg_err, 2'b10);

    // Upper bits of the control readback are ignored
    ovr_en = 1'b1; ovr_addr = 32'h8; ovr_val = 32'hFFFF_FFFD;
    run_seq(32'h1000, 32'h1FFF, 2'b01, -1, lat);
    ovr_en = 1'b0;
    chk("ctl_mask_nxfer", n_xfer, 6);
    chk("ctl_mask_err", cfg_err, 2'b00);

    // Timeout with pready stuck low
    stall = 1'b1;
    run_seq(32'h3000, 32'h3FFF, 2'b10, -1, lat);
    stall = 1'b0;
    chk("to_acc_cycles", acc_cycles, 16);
    chk("to_latency", lat, 18);
    chk("to_nxfer", n_xfer, 0);
    chk("to_err", cfg_err, 2'b11);

    // Second start while busy is ignored
    run_seq(32'h1000, 32'h1FFF, 2'b01, 4, lat);
    chk("rb_nxfer", n_xfer, 6);
    chk("rb_wdata0", log_wdata[0], 32'h1000);
    chk("rb_latency", lat, 13);
    chk("rb_ndone", n_done, 1);
    chk("rb_err", cfg_err, 2'b00);

    // Reset during ACCESS
    wait_states = 2;
    @(negedge pclock);
    cfg_start_addr = 32'h4000; cfg_end_addr = 32'h4FFF; cfg_ctrl = 2'b01;
    cfg_start = 1'b1;
    clear_log();
    @(negedge pclock);
    cfg_start = 1'b0;
    guard = 0;
    while (!(psel && penable) && guard < 50) begin
      @(negedge pclock);
      guard++;
    end
    chk("mr_reached_access", penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel_async", psel, 1'b0);
    chk("mr_penable_async", penable, 1'b0);
    chk("mr_busy_async", cfg_busy, 1'b0);
    repeat (2) @(negedge pclock);
    presetn = 1'b1;
    wait_states = 0;
    repeat (10) @(negedge pclock);
    chk("mr_idle_busy", cfg_busy, 1'b0);
    chk("mr_idle_psel", psel, 1'b0);
    chk("mr_no_done", n_done, 0);
    chk("mr_err", cfg_err, 2'b00);

    // Recovery run after reset
    run_seq(32'h1000, 32'h1FFF, 2'b01, -1, lat);
    chk("post_nxfer", n_xfer, 6);
    chk("post_err", cfg_err, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
